// File: rtl/seven_seg_scan.sv
// Multiplexed 7-segment scanner: double-buffered hex value, per-digit blank slots, anti-ghost gap.
// Optional blinking digits when SEVEN_SEG_BLINK_EN is defined (adds blink_mask port and frame counter).
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;
  localparam logic                  DP_OFF  = ACTIVE_LOW;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [0:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                    dirty_q, dirty_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;
  logic                    frame_end, lit, dark;
  logic [3:0]              nib;

`ifdef SEVEN_SEG_BLINK_EN
  localparam int FW = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
  logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
`endif

  // Scan sequencer: BLANK gap then ON slot per digit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    frame_end = 1'b0;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) begin
        state_d = ST_ON;
        cnt_d   = '0;
      end
      default: if (cnt_q == ON_LAST) begin
        state_d   = ST_BLANK;
        cnt_d     = '0;
        frame_end = (idx_q == IDX_LAST);
        idx_d     = frame_end ? '0 : idx_q + 1'b1;
      end
    endcase
  end

  // Pending buffer takes loads any time; it reaches the display only at a frame boundary.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    dirty_d      = dirty_q;
`ifdef SEVEN_SEG_BLINK_EN
    pend_blink_d = pend_blink_q;
    act_blink_d  = act_blink_q;
    frame_cnt_d  = frame_cnt_q;
    if (frame_end)
      frame_cnt_d = (frame_cnt_q == FW'(2 * BLINK_FRAMES - 1)) ? '0 : frame_cnt_q + 1'b1;
`endif
    if (frame_end && dirty_q) begin
      act_val_d   = pend_val_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
`ifdef SEVEN_SEG_BLINK_EN
      act_blink_d = pend_blink_q;
`endif
      dirty_d     = 1'b0;
    end
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_mask;
`ifdef SEVEN_SEG_BLINK_EN
      pend_blink_d = blink_mask;
`endif
      dirty_d      = 1'b1;
    end
  end

  always_comb begin
`ifdef SEVEN_SEG_BLINK_EN
    dark = act_blink_q[idx_q] && (frame_cnt_q >= FW'(BLINK_FRAMES));
`else
    dark = 1'b0;
`endif
    nib          = act_val_q[{idx_q, 2'b00} +: 4];
    lit          = (state_q == ST_ON) && !act_blank_q[idx_q] && !dark;
    an_d         = lit ? (AN_OFF ^ (NUM_DIGITS'(1) << idx_q)) : AN_OFF;
    seg_d        = lit ? (ACTIVE_LOW ? ~hex7(nib) : hex7(nib)) : SEG_OFF;
    dp_d         = (lit && act_dp_q[idx_q]) ? ~DP_OFF : DP_OFF;
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      dirty_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
      pend_blink_q <= '0;
      act_blink_q  <= '0;
      frame_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      dirty_q      <= dirty_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
`ifdef SEVEN_SEG_BLINK_EN
      pend_blink_q <= pend_blink_d;
      act_blink_q  <= act_blink_d;
      frame_cnt_q  <= frame_cnt_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: time-position model of the scan plus directed literal checks.
module tb_seven_seg_scan;
  localparam int N = 4, R = 8, B = 2, FRAME = N * R;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
`ifdef SEVEN_SEG_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif

  seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .ACTIVE_LOW(1'b1),
                   .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask),
`ifdef SEVEN_SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;

  // Active-high hex glyphs, a..g in bits 0..6.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: everything follows from the number of clocks since reset (n) and the buffered inputs.
  int          m_n = 0;
  bit          m_valid = 0;
  logic [15:0] a_val = '0, p_val = '0;
  logic [3:0]  a_dp = '0, p_dp = '0, a_blk = '0, p_blk = '0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1, e_fd = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_valid = 1; m_n = 0;
      a_val = '0; p_val = '0; a_dp = '0; p_dp = '0; a_blk = '0; p_blk = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      int d, off;
      logic on;
      d   = (m_n / R) % N;
      off = m_n % R;
      on  = (off >= B) && !a_blk[d];
      e_an  = on ? ~(4'b0001 << d) : 4'hF;
      e_seg = on ? ~glyph[(a_val >> (4 * d)) & 16'hF] : 7'h7F;
      e_dp  = on ? ~a_dp[d] : 1'b1;
      e_fd  = (m_n % FRAME) == FRAME - 1;
      if (e_fd) begin a_val = p_val; a_dp = p_dp; a_blk = p_blk; end
      if (load) begin p_val = value; p_dp = dp_in; p_blk = blank_mask; end
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
        errors++;
        $display("FAIL model cyc=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 cyc, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
    end
  end

  // frame_done period monitor
  int last_fd = -1, fd_period = 0;
  always @(negedge clk) if (frame_done === 1'b1) begin
    if (last_fd >= 0) fd_period = cyc - last_fd;
    last_fd = cyc;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] tgt, input string nm);
    bit found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (an === tgt) found = 1;
    end
    if (!found) chk({nm, "_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic wait_fd(input string nm);
    bit found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) found = 1;
    end
    if (!found) chk({nm, "_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] bm);
    value = v; dp_in = d; blank_mask = bm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int hits;
    repeat (3) @(negedge clk);
    chk("reset_an", 16'(an), 16'hF);
    chk("reset_seg", 16'(seg), 16'h7F);
    chk("reset_dp", 16'(dp), 16'h1);
    chk("reset_fd", 16'(frame_done), 16'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("an_before_first_on", 16'(an), 16'hF);
    @(negedge clk);
    chk("first_on_an", 16'(an), 16'hE);
    chk("first_on_seg_zero", 16'(seg), 16'h40);

    repeat (70) @(negedge clk);
    chk("fd_period_free", 16'(fd_period), 16'(FRAME));

    // mid-frame load stays hidden until the boundary
    wait_an(4'b1101, "mid1");
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_fd("fd1");
    wait_an(4'b1110, "d0_1234");
    chk("seg_digit0_4", 16'(seg), 16'h19);
    wait_an(4'b0111, "d3_1234");
    chk("seg_digit3_1", 16'(seg), 16'h79);

    // last of two loads wins
    wait_an(4'b1110, "mid2");
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'hABCD, 4'b0101, 4'b0000);
    wait_fd("fd2");
    wait_an(4'b1110, "d0_abcd");
    chk("seg_digit0_D", 16'(seg), 16'h21);
    chk("dp_digit0_on", 16'(dp), 16'h0);

    // blank mask darkens digit 1 without touching timing
    do_load(16'h5678, 4'b0000, 4'b0010);
    wait_fd("fd3");
    hits = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      if (an === 4'b1101) hits++;
    end
    chk("blank_digit1_never", 16'(hits), 16'd0);
    chk("fd_period_blank", 16'(fd_period), 16'(FRAME));

    // reset during digit 2 ON slot
    wait_an(4'b1011, "d2_on");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_an", 16'(an), 16'hF);
    reset = 1'b0;
    wait_an(4'b1110, "restart_d0");
    chk("restart_seg_zero", 16'(seg), 16'h40);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
